// File: rtl/lamp_sequencer_pkg.sv
// Shared definitions for the traffic controller and its lamp sequencer:
// state encoding, road count and a small sizing helper.
package lamp_sequencer_pkg;

  localparam int NROADS = 4;

  localparam logic [1:0] ST_ALLRED = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_GREEN  = 2'd2;
  localparam logic [1:0] ST_YELLOW = 2'd3;

  typedef enum logic [1:0] {
    S_ALLRED = ST_ALLRED,
    S_IDLE   = ST_IDLE,
    S_GREEN  = ST_GREEN,
    S_YELLOW = ST_YELLOW
  } lamp_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lamp_sequencer_onehot_check.sv
// Classifies a road grant vector: exactly one bit set (valid) or more than
// one bit set (multi). Purely combinational.
module onehot_check
  import lamp_sequencer_pkg::*;
(
  input  logic [NROADS-1:0] vec_i,
  output logic              valid_o,
  output logic              multi_o
);

  localparam int CW = $clog2(NROADS + 1);

  logic [CW-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < NROADS; i++) begin
      ones = ones + CW'(vec_i[i]);
    end
  end

  assign valid_o = (ones == CW'(1));
  assign multi_o = (ones >  CW'(1));

endmodule

// File: rtl/lamp_sequencer.sv
// Drives the red/yellow/green lamps of four roads from a one-hot green grant,
// inserting a yellow phase and an all-red clearance on every grant change.
module lamp_sequencer
  import lamp_sequencer_pkg::*;
#(
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NROADS-1:0] traffic,
  output logic [NROADS-1:0] red,
  output logic [NROADS-1:0] yellow,
  output logic [NROADS-1:0] green,
  output logic              busy,
  output logic              fault
);

  localparam int CNT_W = $clog2(max2(YELLOW_CYC, ALLRED_CYC) + 1);
  localparam logic [CNT_W-1:0] YEL_LOAD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] AR_LOAD  = CNT_W'(ALLRED_CYC - 1);

  lamp_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NROADS-1:0] active_q, active_d;
  logic [NROADS-1:0] red_q, yellow_q, green_q;
  logic              busy_q, fault_q;
  logic              grant_valid, grant_multi;

  onehot_check u_onehot (
    .vec_i   (traffic),
    .valid_o (grant_valid),
    .multi_o (grant_multi)
  );

  // Lamp pattern for a given phase; outputs are registered from the next state
  // so they change on the same edge as the state itself.
  function automatic logic [3*NROADS:0] decode(input lamp_state_e s,
                                               input logic [NROADS-1:0] act);
    logic [NROADS-1:0] r, y, g;
    logic b;
    r = '1;
    y = '0;
    g = '0;
    b = 1'b1;
    case (s)
      S_IDLE:   b = 1'b0;
      S_GREEN:  begin r = ~act; g = act; end
      S_YELLOW: begin r = ~act; y = act; end
      default:  ;
    endcase
    return {r, y, g, b};
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    case (state_q)
      S_ALLRED: begin
        if (cnt_q == '0) begin
          if (grant_valid) begin
            state_d  = S_GREEN;
            active_d = traffic;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (grant_valid) begin
          state_d  = S_GREEN;
          active_d = traffic;
        end
      end
      S_GREEN: begin
        if (traffic != active_q) begin
          state_d = S_YELLOW;
          cnt_d   = YEL_LOAD;
        end
      end
      S_YELLOW: begin
        // Yellow always runs to completion, even if the grant comes back.
        if (cnt_q == '0) begin
          state_d  = S_ALLRED;
          cnt_d    = AR_LOAD;
          active_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = S_ALLRED;
        cnt_d    = AR_LOAD;
        active_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_ALLRED;
      cnt_q    <= AR_LOAD;
      active_q <= '0;
      red_q    <= '1;
      yellow_q <= '0;
      green_q  <= '0;
      busy_q   <= 1'b1;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      {red_q, yellow_q, green_q, busy_q} <= decode(state_d, active_d);
      fault_q  <= grant_multi;
    end
  end

  assign red    = red_q;
  assign yellow = yellow_q;
  assign green  = green_q;
  assign busy   = busy_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Bench for lamp_sequencer: directed scenarios plus randomized grants, each
// compared cycle by cycle against a phase-timing reference model.
module tb_lamp_sequencer;

  localparam int YC = 3;
  localparam int AC = 2;

  localparam int PH_ALLRED = 0;
  localparam int PH_IDLE   = 1;
  localparam int PH_GREEN  = 2;
  localparam int PH_YELLOW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] traffic = 4'b0000;
  logic [3:0] red, yellow, green;
  logic       busy, fault;

  int checks = 0;
  int errors = 0;
  bit inv_en = 0;

  lamp_sequencer #(.YELLOW_CYC(YC), .ALLRED_CYC(AC)) dut (
    .clk     (clk),
    .rst     (rst),
    .traffic (traffic),
    .red     (red),
    .yellow  (yellow),
    .green   (green),
    .busy    (busy),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  wire [13:0] outs = {red, yellow, green, busy, fault};

  // Reference model: phase plus number of cycles already spent in it.
  int         m_phase = PH_ALLRED;
  int         m_t = 0;
  logic [3:0] m_road = 4'b0000;
  logic       m_fault = 1'b0;
  int         m_pc;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = PH_ALLRED;
      m_t     = 0;
      m_road  = 4'b0000;
      m_fault = 1'b0;
    end else begin
      m_pc    = $countones(traffic);
      m_fault = (m_pc > 1);
      m_t     = m_t + 1;
      case (m_phase)
        PH_ALLRED: if (m_t >= AC) begin
          m_t = 0;
          if (m_pc == 1) begin m_phase = PH_GREEN; m_road = traffic; end
          else m_phase = PH_IDLE;
        end
        PH_IDLE: if (m_pc == 1) begin
          m_phase = PH_GREEN; m_road = traffic; m_t = 0;
        end
        PH_GREEN: if (traffic != m_road) begin
          m_phase = PH_YELLOW; m_t = 0;
        end
        default: if (m_t >= YC) begin
          m_phase = PH_ALLRED; m_road = 4'b0000; m_t = 0;
        end
      endcase
    end
  end

  function automatic logic [13:0] exp_vec();
    logic [3:0] r, y, g;
    r = 4'b1111; y = 4'b0000; g = 4'b0000;
    if (m_phase == PH_GREEN)  begin r = ~m_road; g = m_road; end
    if (m_phase == PH_YELLOW) begin r = ~m_road; y = m_road; end
    return {r, y, g, (m_phase != PH_IDLE), m_fault};
  endfunction

  // Lamp invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if ((($countones(green) > 1)) || (green != 0 && yellow != 0) ||
          ((red | yellow | green) != 4'b1111) ||
          ((red & yellow) != 0) || ((red & green) != 0) || ((yellow & green) != 0)) begin
        errors++;
        $display("FAIL invariant r=%b y=%b g=%b", red, yellow, green);
      end
    end
  end

  task automatic drive(input logic [3:0] t, input logic r);
    @(negedge clk);
    traffic = t;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(4'b0001, 1'b1);
    drive(4'b0001, 1'b1);
    inv_en = 1;
    checks++;
    if (outs !== {4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_state got %b exp %b", outs, {4'b1111, 9'b000000001, 1'b0});
    end
    for (int j = 0; j < 2; j++) begin
      drive(4'b0001, 1'b0);
      checks++;
      if (outs !== exp_vec()) begin
        errors++; $display("FAIL reset_release j=%0d got %b exp %b", j, outs, exp_vec());
      end
    end
    checks++;
    if (green !== 4'b0001 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_first_green got g=%b busy=%b exp g=0001 busy=1", green, busy);
    end
  endtask

  task automatic test_handover();
    for (int j = 0; j < 6; j++) begin
      drive(4'b0010, 1'b0);
      checks++;
      if (outs !== exp_vec()) begin
        errors++; $display("FAIL handover j=%0d got %b exp %b", j, outs, exp_vec());
      end
      checks++;
      if (j <= 2 && (yellow !== 4'b0001 || red !== 4'b1110)) begin
        errors++; $display("FAIL handover_yellow j=%0d got y=%b r=%b exp y=0001 r=1110", j, yellow, red);
      end else if ((j == 3 || j == 4) && (red !== 4'b1111 || green !== 4'b0000)) begin
        errors++; $display("FAIL handover_allred j=%0d got r=%b g=%b exp r=1111 g=0000", j, red, green);
      end else if (j == 5 && green !== 4'b0010) begin
        errors++; $display("FAIL handover_green got %b exp 0010", green);
      end
    end
  endtask

  task automatic test_return();
    drive(4'b0001, 1'b0);
    for (int j = 1; j < 6; j++) begin
      drive(4'b0010, 1'b0);
      checks++;
      if (outs !== exp_vec()) begin
        errors++; $display("FAIL return j=%0d got %b exp %b", j, outs, exp_vec());
      end
      checks++;
      if (j <= 2 && yellow !== 4'b0010) begin
        errors++; $display("FAIL return_yellow j=%0d got %b exp 0010", j, yellow);
      end else if (j == 5 && green !== 4'b0010) begin
        errors++; $display("FAIL return_green got %b exp 0010", green);
      end
    end
  endtask

  task automatic test_idle();
    repeat (6) drive(4'b0100, 1'b0);
    checks++;
    if (green !== 4'b0100) begin
      errors++; $display("FAIL idle_setup got %b exp 0100", green);
    end
    for (int j = 0; j < 6; j++) begin
      drive(4'b0000, 1'b0);
      checks++;
      if (outs !== exp_vec()) begin
        errors++; $display("FAIL idle_seq j=%0d got %b exp %b", j, outs, exp_vec());
      end
    end
    checks++;
    if (busy !== 1'b0 || red !== 4'b1111) begin
      errors++; $display("FAIL idle_busy got busy=%b r=%b exp busy=0 r=1111", busy, red);
    end
    drive(4'b1000, 1'b0);
    checks++;
    if (green !== 4'b1000 || busy !== 1'b1) begin
      errors++; $display("FAIL idle_to_green got g=%b busy=%b exp g=1000 busy=1", green, busy);
    end
  endtask

  task automatic test_fault();
    repeat (6) drive(4'b0100, 1'b0);
    drive(4'b0101, 1'b0);
    checks++;
    if (fault !== 1'b1 || yellow !== 4'b0100) begin
      errors++; $display("FAIL fault_set got fault=%b y=%b exp fault=1 y=0100", fault, yellow);
    end
    drive(4'b0100, 1'b0);
    checks++;
    if (fault !== 1'b0 || yellow !== 4'b0100) begin
      errors++; $display("FAIL fault_clear got fault=%b y=%b exp fault=0 y=0100", fault, yellow);
    end
    for (int j = 2; j < 6; j++) begin
      drive(4'b0100, 1'b0);
      checks++;
      if (outs !== exp_vec()) begin
        errors++; $display("FAIL fault_seq j=%0d got %b exp %b", j, outs, exp_vec());
      end
    end
    checks++;
    if (green !== 4'b0100) begin
      errors++; $display("FAIL fault_regrant got %b exp 0100", green);
    end
  endtask

  task automatic test_reset_mid();
    drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b1);
    checks++;
    if (red !== 4'b1111 || yellow !== 4'b0000 || green !== 4'b0000) begin
      errors++; $display("FAIL rstmid_force got r=%b y=%b g=%b exp r=1111 y=0000 g=0000", red, yellow, green);
    end
    for (int j = 0; j < 2; j++) begin
      drive(4'b0001, 1'b0);
      checks++;
      if (outs !== exp_vec()) begin
        errors++; $display("FAIL rstmid_seq j=%0d got %b exp %b", j, outs, exp_vec());
      end
      checks++;
      if (j == 0 && green !== 4'b0000) begin
        errors++; $display("FAIL rstmid_no_green got %b exp 0000", green);
      end
    end
    checks++;
    if (green !== 4'b0001) begin
      errors++; $display("FAIL rstmid_green got %b exp 0001", green);
    end
  endtask

  task automatic test_random();
    logic [3:0] t;
    logic       r;
    int         sel, hold;
    t = 4'b0001;
    for (int k = 0; k < 120; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      t = 4'b0001 << $urandom_range(0, 3);
      else if (sel == 6) t = 4'b0000;
      else if (sel < 9) t = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        r = ($urandom_range(0, 79) == 0);
        drive(t, r);
        checks++;
        if (outs !== exp_vec()) begin
          errors++; $display("FAIL random k=%0d t=%b rst=%b got %b exp %b", k, t, r, outs, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_handover();
    test_return();
    test_idle();
    test_fault();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
